// File: rtl/keypad_pkg.sv
// Shared key codes, key map and scanner FSM state encoding for the keypad time encoder.
package keypad_pkg;

    localparam logic [3:0] KEY_STAR = 4'hE;
    localparam logic [3:0] KEY_HASH = 4'hF;

    typedef logic [1:0] state_t;
    localparam state_t SCAN     = 2'd0;
    localparam state_t DEBOUNCE = 2'd1;
    localparam state_t HELD     = 2'd2;

    // A-D map to 4'hA-4'hD, which the top module treats as "no action".
    function automatic logic [3:0] key_map(input logic [1:0] row, input logic [1:0] col);
        logic [3:0] code;
        code = 4'hA;
        case ({row, col})
            4'b00_00: code = 4'd1;
            4'b00_01: code = 4'd2;
            4'b00_10: code = 4'd3;
            4'b00_11: code = 4'hA;
            4'b01_00: code = 4'd4;
            4'b01_01: code = 4'd5;
            4'b01_10: code = 4'd6;
            4'b01_11: code = 4'hB;
            4'b10_00: code = 4'd7;
            4'b10_01: code = 4'd8;
            4'b10_10: code = 4'd9;
            4'b10_11: code = 4'hC;
            4'b11_00: code = KEY_STAR;
            4'b11_01: code = 4'd0;
            4'b11_10: code = KEY_HASH;
            4'b11_11: code = 4'hD;
            default:  code = 4'hA;
        endcase
        return code;
    endfunction

    function automatic logic [1:0] low_col(input logic [3:0] cols);
        logic [1:0] idx;
        if (!cols[0])      idx = 2'd0;
        else if (!cols[1]) idx = 2'd1;
        else if (!cols[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_time_encoder_scanner.sv
// keypad_scanner: column synchronizer, row scan and press/release debounce FSM.
// Emits a one-cycle key_valid with key_code for each accepted physical press.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    output logic [3:0] row_n,
    output logic [3:0] key_code,
    output logic       key_valid
);

    localparam int unsigned CNT_TOP = (SCAN_DIV > DEBOUNCE_CYCLES) ? SCAN_DIV : DEBOUNCE_CYCLES;
    localparam int unsigned CW      = $clog2(CNT_TOP);

    logic [3:0]    col_m;
    logic [3:0]    col_s;
    state_t        state;
    logic [1:0]    row;
    logic [1:0]    col;
    logic [CW-1:0] cnt;

    always_comb begin
        row_n = 4'b1111;
        row_n[row] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_m     <= 4'b1111;
            col_s     <= 4'b1111;
            state     <= SCAN;
            row       <= 2'd0;
            col       <= 2'd0;
            cnt       <= '0;
            key_code  <= '0;
            key_valid <= 1'b0;
        end else begin
            col_m     <= col_n;
            col_s     <= col_m;
            key_valid <= 1'b0;
            case (state)
                SCAN: begin
                    if (cnt == CW'(SCAN_DIV - 1)) begin
                        cnt <= '0;
                        if (col_s != 4'b1111) begin
                            col   <= low_col(col_s);
                            state <= DEBOUNCE;
                        end else begin
                            row <= row + 2'd1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DEBOUNCE: begin
                    if (col_s[col]) begin
                        state <= SCAN;
                        row   <= row + 2'd1;
                        cnt   <= '0;
                    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                        key_code  <= key_map(row, col);
                        key_valid <= 1'b1;
                        state     <= HELD;
                        cnt       <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                HELD: begin
                    // Any low column (bounce or another key in this row) restarts release timing.
                    if (col_s != 4'b1111) begin
                        cnt <= '0;
                    end else if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                        state <= SCAN;
                        row   <= row + 2'd1;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= SCAN;
                    cnt   <= '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/keypad_time_encoder.sv
// Keypad to BCD time-digit encoder: microwave-style digit shift, lock gating, '#' saturation.
// Optional key-click output enabled by defining KEYPAD_BEEP_EN.
module keypad_time_encoder
    import keypad_pkg::*;
#(
    parameter int unsigned SCAN_DIV        = 1000,
    parameter int unsigned DEBOUNCE_CYCLES = 20000,
    parameter int unsigned BEEP_CYCLES     = 5000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_n,
    input  logic       lock,
    output logic [3:0] row_n,
    output logic [3:0] min,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       digit_pulse,
    output logic       start_pulse,
    output logic       clear_pulse,
    output logic       beep
);

    if (SCAN_DIV < 4 || DEBOUNCE_CYCLES < 2 || BEEP_CYCLES < 1) begin : g_param_check
        $error("keypad_time_encoder: parameter out of range");
    end

    logic [3:0] key_code;
    logic       key_valid;
    logic       do_digit;
    logic       do_clear;
    logic       do_start;

    keypad_scanner #(
        .SCAN_DIV       (SCAN_DIV),
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_scanner (
        .clk      (clk),
        .reset    (reset),
        .col_n    (col_n),
        .row_n    (row_n),
        .key_code (key_code),
        .key_valid(key_valid)
    );

    always_comb begin
        do_digit = key_valid && (key_code <= 4'd9) && !lock;
        do_clear = key_valid && (key_code == KEY_STAR) && !lock;
        do_start = key_valid && (key_code == KEY_HASH);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            min         <= '0;
            sec_tens    <= '0;
            sec_ones    <= '0;
            digit_pulse <= 1'b0;
            start_pulse <= 1'b0;
            clear_pulse <= 1'b0;
        end else begin
            digit_pulse <= do_digit;
            start_pulse <= do_start;
            clear_pulse <= do_clear;
            if (do_digit) begin
                min      <= sec_tens;
                sec_tens <= sec_ones;
                sec_ones <= key_code;
            end else if (do_clear) begin
                min      <= '0;
                sec_tens <= '0;
                sec_ones <= '0;
            end else if (do_start && !lock && (sec_tens > 4'd5)) begin
                sec_tens <= 4'd5;
                sec_ones <= 4'd9;
            end
        end
    end

`ifdef KEYPAD_BEEP_EN
    localparam int unsigned BW = $clog2(BEEP_CYCLES + 1);

    logic [BW-1:0] beep_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            beep_cnt <= '0;
        end else if (do_digit || do_clear || do_start) begin
            beep_cnt <= BW'(BEEP_CYCLES);
        end else if (beep_cnt != '0) begin
            beep_cnt <= beep_cnt - 1'b1;
        end
    end

    assign beep = (beep_cnt != '0);
`else
    assign beep = 1'b0;
`endif

endmodule

// File: tb/tb_keypad_time_encoder.sv
// Directed bench for keypad_time_encoder: SCAN_DIV=4, DEBOUNCE_CYCLES=8, BEEP_CYCLES=3.
module tb_keypad_time_encoder;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] col_n;
    logic       lock;
    logic [3:0] row_n;
    logic [3:0] min;
    logic [3:0] sec_tens;
    logic [3:0] sec_ones;
    logic       digit_pulse;
    logic       start_pulse;
    logic       clear_pulse;
    logic       beep;

    logic       pressed = 1'b0;
    logic [1:0] prow = 2'd0;
    logic [1:0] pcol = 2'd0;

    int total = 0;
    int bad   = 0;

    int dcnt = 0, scnt = 0, ccnt = 0, wide = 0, bcnt = 0;
    logic prev_d = 1'b0, prev_s = 1'b0, prev_c = 1'b0;
    logic [11:0] snap = '0;

    keypad_time_encoder #(
        .SCAN_DIV       (4),
        .DEBOUNCE_CYCLES(8),
        .BEEP_CYCLES    (3)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .col_n      (col_n),
        .lock       (lock),
        .row_n      (row_n),
        .min        (min),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .digit_pulse(digit_pulse),
        .start_pulse(start_pulse),
        .clear_pulse(clear_pulse),
        .beep       (beep)
    );

    always #5 clk = ~clk;

    // Keypad model: the pressed key pulls its column low only while its row is driven.
    always_comb begin
        col_n = 4'b1111;
        if (pressed && !row_n[prow]) col_n[pcol] = 1'b0;
    end

    always @(negedge clk) begin
        if (digit_pulse) dcnt++;
        if (start_pulse) scnt++;
        if (clear_pulse) ccnt++;
        if ((digit_pulse && prev_d) || (start_pulse && prev_s) || (clear_pulse && prev_c)) wide++;
        prev_d = digit_pulse;
        prev_s = start_pulse;
        prev_c = clear_pulse;
        if (start_pulse) snap = {min, sec_tens, sec_ones};
        if (beep) bcnt++;
    end

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Returns at the first negedge of a fresh slot for row r.
    task automatic wait_row(input int r);
        int n;
        n = 0;
        while (row_n[r] == 1'b0 && n < 64) begin @(negedge clk); n++; end
        while (row_n[r] != 1'b0 && n < 64) begin @(negedge clk); n++; end
        if (n >= 64) check("wait_row_timeout", 0, 1);
    endtask

    task automatic press_key(input int r, input int c, input int hold, input int rel);
        prow = 2'(r);
        pcol = 2'(c);
        wait_row(r);
        pressed = 1'b1;
        repeat (hold) @(negedge clk);
        pressed = 1'b0;
        repeat (rel) @(negedge clk);
    endtask

    task automatic check_digits(input string tag, input int m, input int t, input int o);
        check({tag, "_min"}, int'(min), m);
        check({tag, "_tens"}, int'(sec_tens), t);
        check({tag, "_ones"}, int'(sec_ones), o);
    endtask

    int d0, s0, c0, b0;

    initial begin
        reset = 1'b1;
        lock  = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_row_n", int'(row_n), 4'b1110);
        check_digits("rst", 0, 0, 0);
        check("rst_pulses", int'({digit_pulse, start_pulse, clear_pulse}), 0);
        check("rst_beep", int'(beep), 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        // 1: enter 1, 3, 0
        d0 = dcnt;
        press_key(0, 0, 20, 20);
        press_key(0, 2, 20, 20);
        press_key(3, 1, 20, 20);
        check_digits("t1", 1, 3, 0);
        check("t1_dpulses", dcnt - d0, 3);

        // 2: short press of '9' is rejected and scanning moves on to row 3
        d0 = dcnt;
        prow = 2'd2;
        pcol = 2'd2;
        wait_row(2);
        pressed = 1'b1;
        repeat (5) @(negedge clk);
        pressed = 1'b0;
        repeat (4) @(negedge clk);
        check("t2_next_row", int'(row_n), 4'b0111);
        repeat (20) @(negedge clk);
        check("t2_dpulses", dcnt - d0, 0);
        check_digits("t2", 1, 3, 0);

        // 3: 1, 7, 5 then '#' saturates to 1:59 on the start edge
        s0 = scnt;
        press_key(0, 0, 20, 20);
        press_key(2, 0, 20, 20);
        press_key(1, 1, 20, 20);
        check_digits("t3_pre", 1, 7, 5);
        press_key(3, 2, 20, 20);
        check("t3_start", scnt - s0, 1);
        check("t3_snap", int'(snap), 12'h159);
        check_digits("t3", 1, 5, 9);

        // 4: lock blocks digits and clear, but not start
        d0 = dcnt;
        c0 = ccnt;
        s0 = scnt;
        lock = 1'b1;
        press_key(1, 0, 20, 20);
        press_key(3, 0, 20, 20);
        check("t4_dpulses", dcnt - d0, 0);
        check("t4_cpulses", ccnt - c0, 0);
        check_digits("t4", 1, 5, 9);
        press_key(3, 2, 20, 20);
        check("t4_start", scnt - s0, 1);
        check_digits("t4_hash", 1, 5, 9);
        lock = 1'b0;

        // 5: long hold of '2' with release bounce gives a single digit
        d0 = dcnt;
        prow = 2'd0;
        pcol = 2'd1;
        wait_row(0);
        pressed = 1'b1;
        repeat (200) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            pressed = ~pressed;
            @(negedge clk);
        end
        pressed = 1'b0;
        repeat (30) @(negedge clk);
        check("t5_dpulses", dcnt - d0, 1);
        check_digits("t5", 5, 9, 2);

        // 6: reset during debounce of '8', key stays held and is accepted after a fresh debounce
        prow = 2'd2;
        pcol = 2'd1;
        wait_row(2);
        pressed = 1'b1;
        repeat (7) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("t6_row_n", int'(row_n), 4'b1110);
        check_digits("t6_rst", 0, 0, 0);
        check("t6_pulses", int'({digit_pulse, start_pulse, clear_pulse}), 0);
        check("t6_beep", int'(beep), 0);
        d0 = dcnt;
        b0 = bcnt;
        reset = 1'b0;
        repeat (60) @(negedge clk);
        pressed = 1'b0;
        repeat (20) @(negedge clk);
        check("t6_dpulses", dcnt - d0, 1);
        check_digits("t6", 0, 0, 8);
`ifdef KEYPAD_BEEP_EN
        check("t6_beep_len", bcnt - b0, 3);
`else
        check("t6_beep_len", bcnt - b0, 0);
        check("beep_never", bcnt, 0);
`endif

        check("pulse_width", wide, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/keypad_time_encoder.md
Name: keypad_time_encoder

Overview:
- Scans a 4x4 matrix keypad, debounces presses and encodes keys into the three BCD time digits (min, sec_tens, sec_ones) that feed the 7-segment display decoder and the countdown timer.
- Digits enter microwave-style: each new digit shifts in from the right.
- Also emits one-cycle start and clear command pulses to the control FSM.

Parameters:
- SCAN_DIV, 1000, clock cycles each row is driven before advancing (min 4).
- DEBOUNCE_CYCLES, 20000, cycles a press or release must be stable before it is accepted (min 2).
- BEEP_CYCLES, 5000, beep pulse length; used only with the optional feature.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- col_n  in  4  keypad columns, active-low, pulled up, asynchronous to clk.
- lock  in  1  high while the timer runs; blocks digit entry and clear.
- row_n  out  4  keypad row drive, active-low one-hot.
- min  out  4  BCD minutes digit.
- sec_tens  out  4  BCD tens-of-seconds digit.
- sec_ones  out  4  BCD ones-of-seconds digit.
- digit_pulse  out  1  one cycle; a digit was shifted in.
- start_pulse  out  1  one cycle; '#' key accepted.
- clear_pulse  out  1  one cycle; '*' key accepted.
- beep  out  1  key-click output (optional feature only; held 0 otherwise).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high.
- Reset values: row_n=4'b1110, min=sec_tens=sec_ones=0, all pulses=0, beep=0, state=SCAN, counters=0, synchronizer=4'b1111.
- Reset asserted mid-press or mid-debounce aborts to the reset state. A key still held after reset must debounce again before it is accepted.
- col_n passes through a 2-FF synchronizer. All decisions use the synchronized value col_s.
- Key map, row r / col c, index 0 first:
  - r0 = 1 2 3 A
  - r1 = 4 5 6 B
  - r2 = 7 8 9 C
  - r3 = * 0 # D
  - A–D are ignored (no action, no pulse, no beep).
- FSM state SCAN:
  - Drive row k low; slot counter runs 0..SCAN_DIV-1.
  - On the last cycle of the slot, if col_s != 4'b1111: latch row=k and col = lowest-index low column, then go to DEBOUNCE.
  - Otherwise k=(k+1) mod 4, wrapping 3→0.
- FSM state DEBOUNCE:
  - Row stays driven; counter counts cycles with the latched column low.
  - If the column goes high before the count completes, return to SCAN with row k+1.
  - If the counter reaches DEBOUNCE_CYCLES-1, the key is accepted: the action fires on the next cycle, then go to HELD.
- FSM state HELD:
  - Row stays driven; wait for col_s==4'b1111 continuously for DEBOUNCE_CYCLES cycles.
  - Any low column restarts that count.
  - Then go to SCAN with row k+1.
  - Exactly one action per physical press; there is no auto-repeat.
- Actions fire in one cycle; the register update and the pulse happen on the same edge.
  - Digit d with lock=0: min<=sec_tens, sec_tens<=sec_ones, sec_ones<=d, digit_pulse=1. The old min is discarded.
  - '*' with lock=0: all three digits <=0, clear_pulse=1.
  - '#': start_pulse=1 regardless of lock (acts as stop while running).
    - With lock=0, if sec_tens>5, digits saturate on the same edge to sec_tens=5, sec_ones=9; min is unchanged.
  - Digit or '*' with lock=1: no register change, no pulse.
- Multiple keys in one row: lowest column wins. Keys in other rows are invisible until rescanned.
- Outputs are always valid BCD 0–9.

Optional Feature:
- Macro: KEYPAD_BEEP_EN.
- Defined: every accepted key that produces a pulse also loads a down-counter; beep=1 for exactly BEEP_CYCLES cycles, starting on the action cycle. A new action during a beep reloads the counter.
- Undefined: beep is tied 0 and no counter is synthesized.

Decomposition:
- Package keypad_pkg holds:
  - key code constants: KEY_STAR=4'hE, KEY_HASH=4'hF, digits 0–9 as their values;
  - the 4x4 key-map function (row, col) → key code;
  - FSM state typedef {SCAN, DEBOUNCE, HELD}.
- Sub-module keypad_scanner (synchronizer, row scan, debounce FSM) outputs key_code plus a key_valid pulse.
- The top module holds the digit shift register, lock gating, saturation and beep.

Test Plan:
Run all cases with SCAN_DIV=4, DEBOUNCE_CYCLES=8, BEEP_CYCLES=3.
1. Press '1', '3', '0' in sequence (each held 20 cycles, released 20 cycles) → min=1, sec_tens=3, sec_ones=0; three digit_pulse, each exactly 1 cycle wide.
2. Press '9' for 5 cycles only, then release → no pulse, digits unchanged, scan resumes on the next row.
3. Enter 1,7,5, then '#' → start_pulse=1; min=1, sec_tens=5, sec_ones=9 on the same edge.
4. lock=1, press '4' then '*' → digits unchanged, no digit or clear pulse. Then '#' → start_pulse=1.
5. Hold '2' for 200 cycles, with 3 cycles of bounce injected on release → exactly one digit_pulse; sec_ones=2.
6. Assert reset during DEBOUNCE of '8' while the key stays held → outputs return to zero and row_n=4'b1110. The key is accepted once after a fresh debounce. With KEYPAD_BEEP_EN, beep is high for exactly 3 cycles.
